// File: rtl/cic_decim_rt_pkg.sv
// cic_pkg: shared types and elaboration-time helpers for the cic_decim_rt
// decimator (stage mode enum, clog2, derived widths, output shift amount).
package cic_pkg;

    typedef enum logic {
        INTEG = 1'b0,
        COMB  = 1'b1
    } stage_mode_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Internal accumulator width that survives the worst-case gain (R_max*M)^N.
    function automatic int acc_width(input int din_w, input int stages,
                                     input int max_dec_log2, input int diff_delay);
        return din_w + stages * (max_dec_log2 + clog2(diff_delay));
    endfunction

    // Width of the log2(R) configuration field.
    function automatic int rate_width(input int max_dec_log2);
        return clog2(max_dec_log2 + 1);
    endfunction

    localparam int DEF_ACC_WIDTH  = acc_width(16, 3, 6, 1);
    localparam int DEF_RATE_WIDTH = rate_width(6);

    // Right shift that maps the effective growth width W onto the output width.
    function automatic int shift_amt(input int rate, input int stages, input int diff_delay,
                                     input int din_w, input int dout_w);
        return din_w + stages * (rate + clog2(diff_delay)) - dout_w;
    endfunction

endpackage

// File: rtl/cic_decim_rt_if.sv
// cic_decim_rt_if: sample/config/output bundle for the CIC decimator.
// master = upstream driver (mixer/NCO side), slave = the decimator.
interface cic_decim_rt_if
    import cic_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 16,
    parameter int RATE_WIDTH = DEF_RATE_WIDTH
);
    logic signed [DIN_WIDTH-1:0]  din;
    logic                         din_valid;
    logic        [RATE_WIDTH-1:0] dec_log2;
    logic                         cfg_load;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         dout_valid;

    modport master (
        output din, din_valid, dec_log2, cfg_load,
        input  dout, dout_valid
    );

    modport slave (
        input  din, din_valid, dec_log2, cfg_load,
        output dout, dout_valid
    );
endinterface

// File: rtl/cic_decim_rt_stage.sv
// cic_stage: one CIC integrator or comb stage with a clock enable.
// INTEG: acc += din on en.  COMB: dout = din - din delayed by DIFF_DELAY enabled samples.
// All arithmetic wraps modulo 2^WIDTH.
module cic_stage
    import cic_pkg::*;
#(
    parameter stage_mode_e MODE       = INTEG,
    parameter int          WIDTH      = DEF_ACC_WIDTH,
    parameter int          DIFF_DELAY = 1
) (
    input  logic                    clk_in,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] dout
);

    generate
        if (MODE == INTEG) begin : g_integ
            // Wrapping accumulator, advanced only on qualified samples.
            always_ff @(posedge clk_in) begin
                if (clr) begin
                    dout <= '0;
                end else if (en) begin
                    dout <= dout + din;
                end
            end
        end else begin : g_comb
            logic signed [WIDTH-1:0] dly_p0 [DIFF_DELAY];

            // Differentiator against the sample DIFF_DELAY strobes back.
            always_ff @(posedge clk_in) begin
                if (clr) begin
                    dout <= '0;
                    for (int i = 0; i < DIFF_DELAY; i++) begin
                        dly_p0[i] <= '0;
                    end
                end else if (en) begin
                    dout      <= din - dly_p0[DIFF_DELAY-1];
                    dly_p0[0] <= din;
                    for (int i = 1; i < DIFF_DELAY; i++) begin
                        dly_p0[i] <= dly_p0[i-1];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cic_decim_rt.sv
// cic_decim_rt: N-stage CIC decimator with runtime power-of-two rate.
// Integrators -> strobe-based decimation -> combs -> registered output scaling.
// Build option: define CIC_ROUND_EN for round-half-up with saturation on the
// output; otherwise the output is truncated toward -inf.
module cic_decim_rt
    import cic_pkg::*;
#(
    parameter int DIN_WIDTH    = 16,
    parameter int DOUT_WIDTH   = 16,
    parameter int STAGES       = 3,
    parameter int MAX_DEC_LOG2 = 6,
    parameter int DIFF_DELAY   = 1
) (
    input  logic          clk_in,
    input  logic          rst,
    cic_decim_rt_if.slave bus
);

    localparam int ACC_WIDTH  = acc_width(DIN_WIDTH, STAGES, MAX_DEC_LOG2, DIFF_DELAY);
    localparam int RATE_WIDTH = rate_width(MAX_DEC_LOG2);
    localparam int CNT_WIDTH  = MAX_DEC_LOG2;

    logic                         flush;
    logic        [RATE_WIDTH-1:0] rate_q;
    logic        [STAGES:0]       vld;
    logic        [STAGES-1:0]     vld_d;
    logic        [STAGES:0]       stb;
    logic        [STAGES-1:0]     stb_d;
    logic signed [ACC_WIDTH-1:0]  integ [STAGES+1];
    logic signed [ACC_WIDTH-1:0]  comb  [STAGES+1];
    logic        [CNT_WIDTH-1:0]  cnt;
    logic        [CNT_WIDTH-1:0]  cnt_last;
    logic                         dec_hit;
    logic signed [DOUT_WIDTH-1:0] scaled;

    function automatic logic [RATE_WIDTH-1:0] clamp_rate(input logic [RATE_WIDTH-1:0] req);
        if (int'(req) > MAX_DEC_LOG2) begin
            return RATE_WIDTH'(MAX_DEC_LOG2);
        end
        return req;
    endfunction

`ifdef CIC_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        (ACC_WIDTH+1)'((64'sd1 <<< (DOUT_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        (ACC_WIDTH+1)'(-(64'sd1 <<< (DOUT_WIDTH-1)));

    function automatic logic signed [DOUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH:0] v);
        if (v > OUT_MAX) begin
            return {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
        if (v < OUT_MIN) begin
            return {1'b1, {(DOUT_WIDTH-1){1'b0}}};
        end
        return v[DOUT_WIDTH-1:0];
    endfunction

    // Round half up, then clamp; one extra bit keeps the bias add from wrapping.
    function automatic logic signed [DOUT_WIDTH-1:0] scale_round(
        input logic signed [ACC_WIDTH-1:0] x, input logic [RATE_WIDTH-1:0] rate);
        logic signed [ACC_WIDTH:0] wide;
        logic signed [ACC_WIDTH:0] half;
        logic signed [ACC_WIDTH:0] biased;
        int sh;
        wide   = (ACC_WIDTH+1)'(x);
        half   = '0;
        biased = wide;
        sh     = 0;
        for (int r = 0; r <= MAX_DEC_LOG2; r++) begin
            if (int'(rate) == r) begin
                sh = shift_amt(r, STAGES, DIFF_DELAY, DIN_WIDTH, DOUT_WIDTH);
            end
        end
        if (sh > 0) begin
            half   = (ACC_WIDTH+1)'(1) << (sh - 1);
            biased = wide + half;
            biased = biased >>> sh;
        end
        return sat_out(biased);
    endfunction
`else
    // Arithmetic shift selected by rate, keeping the low DOUT_WIDTH bits.
    function automatic logic signed [DOUT_WIDTH-1:0] scale_trunc(
        input logic signed [ACC_WIDTH-1:0] x, input logic [RATE_WIDTH-1:0] rate);
        logic signed [ACC_WIDTH-1:0] shifted;
        shifted = x;
        for (int r = 0; r <= MAX_DEC_LOG2; r++) begin
            if (int'(rate) == r) begin
                shifted = x >>> shift_amt(r, STAGES, DIFF_DELAY, DIN_WIDTH, DOUT_WIDTH);
            end
        end
        return shifted[DOUT_WIDTH-1:0];
    endfunction
`endif

    assign flush = rst | bus.cfg_load;

    // Rate is latched only on reset or cfg_load; clamped to the supported maximum.
    always_ff @(posedge clk_in) begin
        if (flush) begin
            rate_q <= clamp_rate(bus.dec_log2);
        end
    end

    // ---- integrator section: valid bit travels one stage per cycle ----
    assign vld = {vld_d, bus.din_valid};

    // Valid pipeline alongside the integrator chain.
    always_ff @(posedge clk_in) begin
        if (flush) begin
            vld_d <= '0;
        end else begin
            vld_d <= vld[STAGES-1:0];
        end
    end

    assign integ[0] = ACC_WIDTH'(bus.din);

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_integ
            cic_stage #(
                .MODE       (INTEG),
                .WIDTH      (ACC_WIDTH),
                .DIFF_DELAY (DIFF_DELAY)
            ) u_stage (
                .clk_in (clk_in),
                .clr    (flush),
                .en     (vld[k]),
                .din    (integ[k]),
                .dout   (integ[k+1])
            );
        end
    endgenerate

    // ---- decimator: every R-th integrator output strobes the combs ----
    assign cnt_last = CNT_WIDTH'((32'd1 << rate_q) - 32'd1);
    assign dec_hit  = vld[STAGES] && (cnt == cnt_last);

    // Sample counter within the current R-sample group.
    always_ff @(posedge clk_in) begin
        if (flush) begin
            cnt <= '0;
        end else if (vld[STAGES]) begin
            cnt <= dec_hit ? '0 : cnt + 1'b1;
        end
    end

    // ---- comb section: strobe travels one stage per cycle ----
    assign stb     = {stb_d, dec_hit};
    assign comb[0] = integ[STAGES];

    // Strobe pipeline alongside the comb chain.
    always_ff @(posedge clk_in) begin
        if (flush) begin
            stb_d <= '0;
        end else begin
            stb_d <= stb[STAGES-1:0];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_comb
            cic_stage #(
                .MODE       (COMB),
                .WIDTH      (ACC_WIDTH),
                .DIFF_DELAY (DIFF_DELAY)
            ) u_stage (
                .clk_in (clk_in),
                .clr    (flush),
                .en     (stb[k]),
                .din    (comb[k]),
                .dout   (comb[k+1])
            );
        end
    endgenerate

    // ---- output stage: scale and register, hold between strobes ----
    // Select the scaling flavour for the comb output.
    always_comb begin
`ifdef CIC_ROUND_EN
        scaled = scale_round(comb[STAGES], rate_q);
`else
        scaled = scale_trunc(comb[STAGES], rate_q);
`endif
    end

    // Output register; dout only changes on a strobe.
    always_ff @(posedge clk_in) begin
        if (flush) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= stb[STAGES];
            if (stb[STAGES]) begin
                bus.dout <= scaled;
            end
        end
    end

endmodule
